// File: rtl/bist_misr_compactor.sv
// ---------------------------------------------------------------------------
// bist_misr_compactor
// Multiple-input signature register that compacts the core's BIST result
// stream into a signature, then compares the final signature to a golden
// value. Runs in the TCK domain next to the BIST sequencer.
//
// Ports
//   clk           in   TCK, rising-edge
//   rst           in   asynchronous active-high reset
//   start         in   begin a compaction run (pulse)
//   stop          in   end run and freeze signature (pulse)
//   sample_valid  in   sample_data valid this cycle
//   sample_data   in   DATA_W core result sample
//   golden        in   SIG_W expected signature, sampled on entry to DONE
//   signature     out  SIG_W current/final MISR contents
//   sig_valid     out  signature is final (DONE)
//   pass          out  final signature matched golden with no overflow
//   busy          out  run in progress (RUN)
//   sample_count  out  CNT_W saturating count of absorbed samples
//   overflow      out  more samples offered than the counter can hold
// ---------------------------------------------------------------------------
module bist_misr_compactor #(
    parameter int unsigned           DATA_W = 4,
    parameter int unsigned           SIG_W  = 14,
    parameter logic [SIG_W-1:0]      POLY   = 14'h0443,
    parameter logic [SIG_W-1:0]      SEED   = 14'h0001,
    parameter int unsigned           CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [SIG_W-1:0]  golden,
    output logic [SIG_W-1:0]  signature,
    output logic              sig_valid,
    output logic              pass,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               pass_q, pass_d;
    logic [SIG_W-1:0]   misr_next;

    // Galois-form MISR step: shift, fold the MSB back through the taps, xor sample in
    always_comb begin
        misr_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(sample_data);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start wins over stop outside RUN; a reseed clears the previous verdict
                if (start) begin
                    state_d = ST_RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    sig_d = misr_next;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A sample on the stop cycle is part of the final signature
                if (stop) begin
                    state_d = ST_DONE;
                    pass_d  = (sig_d == golden) && !ovf_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pass_q  <= pass_d;
        end
    end

    assign signature    = sig_q;
    assign sample_count = cnt_q;
    assign overflow     = ovf_q;
    assign pass         = pass_q;
    assign busy         = (state_q == ST_RUN);
    assign sig_valid    = (state_q == ST_DONE);

endmodule
